// File: rtl/rx_axis_sink.sv
// AXI-stream RX sink: 64-bit beat FIFO read back as two 32-bit words (low half first).
// Define RX_SINK_DROP_EN for drop mode (tready tied high, beats discarded when full).
module rx_axis_sink #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axis_tvalid_i,
  input  logic [63:0]           axis_tdata_i,
  output logic                  axis_tready_o,
  input  logic                  rd_en_i,
  output logic [31:0]           rd_data_o,
  output logic                  rd_valid_o,
  output logic [DEPTH_LOG2:0]   fill_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_i
);

  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [63:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic                  r_hs;
  logic [DEPTH_LOG2:0]   r_fill;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_free;
  logic        w_lost;
  logic [31:0] w_rd_word;

  assign w_full  = (r_fill == FILL_FULL);
  assign w_empty = (r_fill == '0);

`ifdef RX_SINK_DROP_EN
  assign axis_tready_o = 1'b1;
`else
  assign axis_tready_o = !w_full;
`endif

  // Full is judged on registered fill, so a same-cycle freeing pop never rescues a beat.
  assign w_push    = !clr_i && axis_tvalid_i && axis_tready_o && !w_full;
  assign w_lost    = !clr_i && axis_tvalid_i && w_full;
  assign w_pop     = !clr_i && rd_en_i && !w_empty;
  assign w_free    = w_pop && r_hs;
  assign w_rd_word = r_hs ? r_mem[r_rp][63:32] : r_mem[r_rp][31:0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= axis_tdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_hs        <= 1'b0;
      r_fill      <= '0;
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      if (clr_i) begin
        r_wp        <= '0;
        r_rp        <= '0;
        r_hs        <= 1'b0;
        r_fill      <= '0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop) begin
          rd_data_o  <= w_rd_word;
          rd_valid_o <= 1'b1;
          r_hs       <= !r_hs;
        end
        if (w_free) r_rp <= r_rp + 1'b1;
        if (w_push && !w_free)      r_fill <= r_fill + 1'b1;
        else if (!w_push && w_free) r_fill <= r_fill - 1'b1;
        if (w_lost) overflow_o <= 1'b1;
        if (rd_en_i && w_empty) underflow_o <= 1'b1;
      end
    end
  end

  assign fill_o = r_fill;

endmodule

// File: tb/tb_rx_axis_sink.sv
// Randomized scoreboard bench for rx_axis_sink (DEPTH_LOG2=2); model is a queue of 32-bit words.
module tb_rx_axis_sink;

  localparam int unsigned DL2   = 2;
  localparam int unsigned DEPTH = 2**DL2;
`ifdef RX_SINK_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           axis_tvalid_i = 1'b0;
  logic [63:0]    axis_tdata_i = '0;
  logic           axis_tready_o;
  logic           rd_en_i = 1'b0;
  logic [31:0]    rd_data_o;
  logic           rd_valid_o;
  logic [DL2:0]   fill_o;
  logic           overflow_o;
  logic           underflow_o;
  logic           clr_i = 1'b0;

  rx_axis_sink #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst),
    .axis_tvalid_i(axis_tvalid_i), .axis_tdata_i(axis_tdata_i), .axis_tready_o(axis_tready_o),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .fill_o(fill_o), .overflow_o(overflow_o), .underflow_o(underflow_o), .clr_i(clr_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic v; logic [31:0] d; } exp_t;
  exp_t        sb[$];
  logic [31:0] words[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
  endtask

  function automatic int unsigned model_fill();
    return (words.size() + 1) / 2;
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rd_valid", 64'(rd_valid_o), 64'(e.v));
      if (e.v) chk("rd_data", 64'(rd_data_o), 64'(e.d));
    end else if (rd_valid_o) begin
      chk("rd_valid_unexpected", 64'(rd_valid_o), 64'd0);
    end
  end

  // Called at a falling edge: check registered state, drive one cycle, advance the model.
  task automatic cycle(input logic v, input logic [63:0] d, input logic rd, input logic c,
                       output logic acc);
    int unsigned fm;
    logic        full;
    exp_t        e;
    fm   = model_fill();
    full = (fm == DEPTH);
    chk("fill", 64'(fill_o), 64'(fm));
    chk("tready", 64'(axis_tready_o), DROP ? 64'd1 : 64'(!full));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("underflow", 64'(underflow_o), 64'(m_unf));
    axis_tvalid_i = v; axis_tdata_i = d; rd_en_i = rd; clr_i = c;
    e.v = 1'b0; e.d = '0; acc = 1'b0;
    if (c) begin
      words.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (rd) begin
        if (words.size() > 0) begin e.v = 1'b1; e.d = words.pop_front(); end
        else m_unf = 1'b1;
      end
      if (v) begin
        if (full) m_ovf = 1'b1;
        else begin words.push_back(d[31:0]); words.push_back(d[63:32]); acc = 1'b1; end
      end
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rd_data", 64'(rd_data_o), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_fill", 64'(fill_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_underflow", 64'(underflow_o), 64'd0);
    chk("rst_tready", 64'(axis_tready_o), 64'd1);
  endtask

  task automatic do_reset();
    exp_t e;
    axis_tvalid_i = 1'b0; rd_en_i = 1'b0; clr_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    words.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    e.v = 1'b0; e.d = '0;
    sb.push_back(e);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 4*DEPTH + 4 && words.size() > 0; t++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
    chk("drain_empty", 64'(words.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [63:0] d;
    #1 rst = 1'b1;
    #2 chk_reset_vals();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single beat, two word reads.
    cycle(1'b1, 64'hAAAA_BBBB_1111_2222, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);

    // Empty read, sticky underflow, then clear.
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);

    // Five beats into a four-entry FIFO.
    for (int b = 0; b < 4; b++) cycle(1'b1, {32'hB0B0_0000 + b, 32'hA0A0_0000 + b}, 1'b0, 1'b0, acc);
    chk("full_fill", 64'(fill_o), 64'd4);
    if (DROP) begin
      cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0, acc);
      chk("drop_not_accepted", 64'(acc), 64'd0);
      cycle(1'b0, '0, 1'b0, 1'b0, acc);
    end else begin
      chk("bp_tready_low", 64'(axis_tready_o), 64'd0);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++)
        cycle(1'b1, 64'hDEAD_BEEF_C0DE_0004, (t >= 3 && t < 5), 1'b0, acc);
      chk("bp_fifth_accepted", 64'(acc), 64'd1);
      cycle(1'b0, '0, 1'b0, 1'b0, acc);
    end
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1, acc);

    // Push every other cycle, read every cycle, across pointer wrap.
    for (int c = 0; c < 6*DEPTH + 2; c++) begin
      d = {$urandom, $urandom};
      cycle(c[0] == 1'b0 && c < 6*DEPTH, d, 1'b1, 1'b0, acc);
      chk("wrap_fill_le1", 64'(fill_o <= 1), 64'd1);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, acc);

    // Push concurrent with high-half pop at fill 3.
    for (int b = 0; b < 3; b++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, acc);
    chk("simul_fill3", 64'(fill_o), 64'd3);
    drain();

    // Reset with partially read entry, then restart from low half.
    for (int b = 0; b < 3; b++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    do_reset();
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);

    // Random traffic with varying push/pop pressure.
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 600; c++) begin
        logic v, r, k;
        v = ($urandom_range(0, 99) < (seg == 0 ? 70 : seg == 1 ? 30 : 50));
        r = ($urandom_range(0, 99) < (seg == 0 ? 40 : seg == 1 ? 80 : 50));
        k = ($urandom_range(0, 127) == 0);
        cycle(v, {$urandom, $urandom}, r, k, acc);
      end
    end
    drain();
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    @(posedge clk); #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
